// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between four byte requesters.
// One byte per grant; a watchdog aborts a transfer whose done never arrives.
module uart_tx_arbiter #(
  parameter int unsigned CLKS_PER_BIT = 104,
  parameter int unsigned TIMEOUT_CLKS = 10 * CLKS_PER_BIT + 60
) (
  input  logic        i_Clock,
  input  logic        i_Reset,
  input  logic [3:0]  i_Req,
  input  logic [31:0] i_Req_Byte,
  output logic [3:0]  o_Ack,
  output logic [3:0]  o_Sent,
  output logic [1:0]  o_Grant_Idx,
  output logic        o_Busy,
  output logic        o_Timeout,
  output logic        o_Tx_DV,
  output logic [7:0]  o_Tx_Byte,
  input  logic        i_Tx_Done
);

  localparam logic [15:0] WdLast = 16'(TIMEOUT_CLKS - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWaitDone, StGuard} state_e;

  state_e      state_q, state_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [1:0]  grant_q, grant_d;
  logic [3:0]  ack_q, ack_d;
  logic [3:0]  sent_q, sent_d;
  logic        busy_q, busy_d;
  logic        timeout_q, timeout_d;
  logic        tx_dv_q, tx_dv_d;
  logic [7:0]  tx_byte_q, tx_byte_d;
  logic [15:0] wd_q, wd_d;

  logic        sel_valid;
  logic [1:0]  sel;
  logic [1:0]  cand;

  // First set request after the last grant, wrapping modulo 4.
  always_comb begin
    sel_valid = 1'b0;
    sel       = ptr_q;
    cand      = ptr_q;
    for (int k = 1; k <= 4; k++) begin
      cand = ptr_q + 2'(k);
      if (!sel_valid && i_Req[cand]) begin
        sel_valid = 1'b1;
        sel       = cand;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    ack_d     = 4'b0000;
    sent_d    = 4'b0000;
    timeout_d = 1'b0;
    tx_dv_d   = 1'b0;
    tx_byte_d = tx_byte_q;
    wd_d      = wd_q;
    unique case (state_q)
      StIdle: begin
        if (sel_valid) begin
          grant_d   = sel;
          ptr_d     = sel;
          tx_byte_d = i_Req_Byte[{sel, 3'b000} +: 8];
          ack_d     = 4'b0001 << sel;
          tx_dv_d   = 1'b1;
          state_d   = StIssue;
        end
      end
      StIssue: begin
        wd_d    = '0;
        state_d = StWaitDone;
      end
      StWaitDone: begin
        if (i_Tx_Done) begin
          sent_d  = 4'b0001 << grant_q;
          state_d = StGuard;
        end else if (wd_q == WdLast) begin
          timeout_d = 1'b1;
          state_d   = StGuard;
        end else begin
          wd_d = wd_q + 16'd1;
        end
      end
      StGuard: begin
        // uart_tx holds done for two cycles; wait it out so it cannot end the next frame.
        if (!i_Tx_Done) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q   <= StIdle;
      ptr_q     <= 2'd3;
      grant_q   <= 2'd0;
      ack_q     <= 4'b0000;
      sent_q    <= 4'b0000;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      tx_dv_q   <= 1'b0;
      tx_byte_q <= 8'h00;
      wd_q      <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
      ack_q     <= ack_d;
      sent_q    <= sent_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
      tx_dv_q   <= tx_dv_d;
      tx_byte_q <= tx_byte_d;
      wd_q      <= wd_d;
    end
  end

  assign o_Ack       = ack_q;
  assign o_Sent      = sent_q;
  assign o_Grant_Idx = grant_q;
  assign o_Busy      = busy_q;
  assign o_Timeout   = timeout_q;
  assign o_Tx_DV     = tx_dv_q;
  assign o_Tx_Byte   = tx_byte_q;

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin arbiter that shares one uart_tx transmitter between four byte-producing requesters. It sits between the requesters and the transmitter's i_Tx_DV / i_Tx_Byte / o_Tx_Done interface. It issues one byte per grant and waits for the transmitter's done pulse before granting again. A watchdog recovers the arbiter if the transmitter never reports done.

Parameters:
CLKS_PER_BIT, 104, UART bit period in i_Clock cycles; informational, used only for the TIMEOUT_CLKS default.
TIMEOUT_CLKS, 1100, maximum cycles spent in WAIT_DONE before abort; must be > 10*CLKS_PER_BIT+4 and < 65536.

Ports:
i_Clock  in  1  system clock; all logic on rising edge.
i_Reset  in  1  synchronous, active-high reset.
i_Req  in  4  per-requester request; bit k held high until o_Ack[k].
i_Req_Byte  in  32  requester k byte on bits [8k+7:8k]; must be stable while i_Req[k] is high.
o_Ack  out  4  one-hot, one-cycle pulse: byte of requester k accepted.
o_Sent  out  4  one-hot, one-cycle pulse: byte of requester k fully transmitted.
o_Grant_Idx  out  2  index of current or last granted requester.
o_Busy  out  1  high in any state other than IDLE.
o_Timeout  out  1  one-cycle pulse when the watchdog aborts a transfer.
o_Tx_DV  out  1  to uart_tx i_Tx_DV.
o_Tx_Byte  out  8  to uart_tx i_Tx_Byte; holds the last issued byte.
i_Tx_Done  in  1  from uart_tx o_Tx_Done.

Behaviour:
- Reset: all outputs 0, o_Tx_Byte=0, state=IDLE, last-grant pointer=3 (so requester 0 has first priority), watchdog=0. Reset mid-transfer aborts immediately: no o_Sent, no o_Timeout. The transmitter is not reset by this block.
- All outputs registered.
- States: IDLE, ISSUE, WAIT_DONE, GUARD.
- IDLE:
  - If i_Req != 0, select the first set bit searching from pointer+1 upward, modulo 4.
  - Latch its byte into o_Tx_Byte, set o_Grant_Idx and the pointer to the selected index, go to ISSUE.
  - Else stay in IDLE.
- ISSUE (exactly 1 cycle):
  - o_Tx_DV=1 and o_Ack[g]=1 in this same cycle.
  - Clear the watchdog, go to WAIT_DONE.
  - Latency: request seen high at IDLE edge N → o_Tx_DV/o_Ack high during cycle N+1.
- WAIT_DONE:
  - o_Tx_DV=0; the watchdog increments each cycle.
  - i_Tx_Done=1 → o_Sent[g] pulses next cycle, go to GUARD.
  - Else, watchdog reaching TIMEOUT_CLKS-1 → o_Timeout pulses next cycle, no o_Sent, go to GUARD.
  - If done and timeout coincide, done wins.
- GUARD:
  - Wait for i_Tx_Done==0 (uart_tx holds done high 2 cycles), then go to IDLE.
  - Prevents a stale done from completing the next transfer.
  - Stays indefinitely if done is stuck high; o_Busy remains 1.
- Requests are sampled only in IDLE. A request dropped before its grant is ignored. Requests arriving during a transfer wait.
- Fairness: a continuously asserted requester cannot win twice in a row while any other request is pending.
- Back-to-back throughput: one byte per 10*CLKS_PER_BIT + 5 cycles (ISSUE, transmitter frame, done, GUARD exit, IDLE).
- o_Ack and o_Sent are never both set for different indices in the same cycle; at most one bit of each is set.

Test Plan:
- Single request: i_Req=4'b0100 with byte 0xA5 → o_Grant_Idx=2, o_Ack=4'b0100 for 1 cycle with o_Tx_DV=1 and o_Tx_Byte=0xA5. The serial line carries 0xA5, o_Sent=4'b0100 once, o_Busy returns to 0.
- All four requesting from reset, bytes 0x10/0x21/0x32/0x43, each released on its ack → grant order 0,1,2,3. Four serial frames in that order, four o_Sent pulses.
- Fairness: req0 held continuously, req2 asserted after the first grant → grant sequence 0,2,0,2…; req2 is never skipped.
- Timeout: model transmitter with i_Tx_Done tied 0 → o_Timeout pulses exactly TIMEOUT_CLKS+1 cycles after the o_Tx_DV cycle, no o_Sent. The next request is then granted normally.
- Stuck done: i_Tx_Done held 1 after a transfer → arbiter stays in GUARD with o_Busy=1 and no new o_Ack. Releasing done → returns to IDLE and serves the pending request.
- Reset mid-transfer: assert i_Reset for 1 cycle during WAIT_DONE → all outputs 0, pointer=3. No o_Sent or o_Timeout for the aborted byte. With req1 and req3 pending, req1 is granted first.
